mem_sp_stream_rd: RTL and testbench

- Reader/streamer for a single-port xKx32 buffer memory with byte-enabled writes and registered read data.
- On a start command it reads LEN consecutive words from BASE_ADDR and presents them as a valid/ready stream toward the FT601 TX path.
- It owns the memory port while busy and never writes it.
- A 2-entry output buffer absorbs the 1-cycle read latency, giving 1 word/cycle throughput under continuous ready.

---
 rtl/mem_sp_stream_rd.sv | 150 +++++++++++++++
 tb/tb_mem_sp_stream_rd.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sp_stream_rd.sv
// Streams LEN consecutive words out of a single-port buffer memory onto a valid/ready
// interface; a 2-entry skid FIFO hides the one-cycle registered read latency.
module mem_sp_stream_rd #(
    parameter int T_MSZ       = 12,
    parameter int WIDTH_DATA  = 32,
    parameter int CNT_CHANNLS = 4
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   start,
    input  logic [T_MSZ-1:0]       base_addr,
    input  logic [T_MSZ:0]         len,
    input  logic [CNT_CHANNLS-1:0] last_be,
    output logic                   busy,
    output logic                   done,
    output logic [T_MSZ-1:0]       mem_a,
    output logic                   mem_ce,
    output logic [CNT_CHANNLS-1:0] mem_we,
    input  logic [WIDTH_DATA-1:0]  mem_q,
    output logic [WIDTH_DATA-1:0]  m_data,
    output logic [CNT_CHANNLS-1:0] m_be,
    output logic                   m_valid,
    output logic                   m_last,
    input  logic                   m_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                   state_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic [T_MSZ-1:0]         addr_reg;
    logic [T_MSZ:0]           rd_cnt_reg;
    logic [T_MSZ:0]           out_cnt_reg;
    logic [CNT_CHANNLS-1:0]   last_be_reg;
    logic                     inflight_reg;
    logic                     inflight_last_reg;

    logic [WIDTH_DATA-1:0]    fifo_data [0:1];
    logic [CNT_CHANNLS-1:0]   fifo_be   [0:1];
    logic                     fifo_last [0:1];
    logic                     wr_ptr_reg;
    logic                     rd_ptr_reg;
    logic [1:0]               fifo_cnt_reg;

    logic                     pop;
    logic                     push;
    logic                     issue;
    logic [2:0]               occ;

    assign pop  = (fifo_cnt_reg != 2'd0) && m_ready;
    assign push = inflight_reg;
    assign occ  = {1'b0, fifo_cnt_reg} + {2'b00, inflight_reg};

    // Words already buffered plus the one in flight must leave room, counting the
    // slot freed by a handshake happening this same cycle.
    assign issue = (state_reg == ST_RUN) && (rd_cnt_reg != '0) &&
                   (occ < (3'd2 + {2'b00, pop}));

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign mem_a   = addr_reg;
    assign mem_ce  = issue;
    assign mem_we  = '0;
    assign m_valid = (fifo_cnt_reg != 2'd0);
    assign m_data  = fifo_data[rd_ptr_reg];
    assign m_be    = fifo_be[rd_ptr_reg];
    assign m_last  = m_valid && fifo_last[rd_ptr_reg];

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            addr_reg          <= '0;
            rd_cnt_reg        <= '0;
            out_cnt_reg       <= '0;
            last_be_reg       <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            wr_ptr_reg        <= 1'b0;
            rd_ptr_reg        <= 1'b0;
            fifo_cnt_reg      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_be[i]   <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            done_reg          <= 1'b0;
            inflight_reg      <= issue;
            inflight_last_reg <= issue && (rd_cnt_reg == 1);

            if (push) begin
                fifo_data[wr_ptr_reg] <= mem_q;
                fifo_be[wr_ptr_reg]   <= inflight_last_reg ? last_be_reg : '1;
                fifo_last[wr_ptr_reg] <= inflight_last_reg;
                wr_ptr_reg            <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg  <= ~rd_ptr_reg;
                out_cnt_reg <= out_cnt_reg - 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        addr_reg    <= base_addr;
                        rd_cnt_reg  <= len;
                        out_cnt_reg <= len;
                        last_be_reg <= last_be;
                        if (len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        addr_reg   <= addr_reg + 1'b1;
                        rd_cnt_reg <= rd_cnt_reg - 1'b1;
                        if (rd_cnt_reg == 1) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && (out_cnt_reg == 1)) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sp_stream_rd.sv
// Randomised bench for mem_sp_stream_rd: a memory model feeds the DUT, expected words are
// queued when each command is issued, and a negedge monitor checks every handshake.
module tb_mem_sp_stream_rd;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic [BW-1:0] last_be = '0;
    logic          busy, done, mem_ce, m_valid, m_last;
    logic          m_ready = 1'b0;
    logic [AW-1:0] mem_a;
    logic [BW-1:0] mem_we, m_be;
    logic [DW-1:0] mem_q = '0;
    logic [DW-1:0] m_data;

    mem_sp_stream_rd #(.T_MSZ(AW), .WIDTH_DATA(DW), .CNT_CHANNLS(BW)) dut (
        .CLK(CLK), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .last_be(last_be), .busy(busy), .done(done), .mem_a(mem_a), .mem_ce(mem_ce),
        .mem_we(mem_we), .mem_q(mem_q), .m_data(m_data), .m_be(m_be),
        .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge CLK) if (mem_ce) mem_q <= mem[mem_a];

    typedef struct packed {
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        logic          last;
    } word_t;

    word_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            checks = 0;
    int            failures = 0;
    int            ready_mode = 0;
    int            hs_count = 0;
    int            zero_req = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    initial begin
        int rcyc = 0;
        forever begin
            @(posedge CLK); #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            rcyc++;
        end
    end

    // Monitor / scoreboard.
    initial begin
        int    issued = 0;
        int    popped = 0;
        int    zero_ack = 0;
        logic  done_due = 1'b0;
        logic  stall = 1'b0;
        logic  due;
        logic  pop;
        word_t held;
        word_t w;
        forever begin
            @(negedge CLK);
            if (rst) begin
                done_due = 1'b0; zero_ack = zero_req; issued = 0; popped = 0; stall = 1'b0;
            end else begin
                pop = m_valid && m_ready;
                due = done_due || (zero_ack != zero_req);
                zero_ack = zero_req;
                if (done || due) chk("done_pulse", 64'(done), 64'(due));
                done_due = 1'b0;
                if (stall) begin
                    chk("stall_valid", 64'(m_valid), 64'd1);
                    chk("stall_hold", 64'({m_data, m_be, m_last}), 64'(held));
                end
                if (mem_ce) begin
                    chk("credit", 64'((issued - popped - int'(pop)) < 2), 64'd1);
                    chk("mem_we", 64'(mem_we), 64'd0);
                    if (addr_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_read actual=0x%0h required=none", mem_a);
                    end else begin
                        chk("mem_a", 64'(mem_a), 64'(addr_q.pop_front()));
                    end
                    issued++;
                end
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_word actual=0x%0h required=none", m_data);
                    end else begin
                        w = exp_q.pop_front();
                        chk("word", 64'({m_data, m_be, m_last}), 64'(w));
                    end
                    if (m_last) done_due = 1'b1;
                    popped++;
                    hs_count++;
                end
                stall = m_valid && !m_ready;
                held  = '{data: m_data, be: m_be, last: m_last};
            end
        end
    end

    // Drives a start pulse; expectations are queued only if the DUT is idle.
    task automatic issue(input logic [AW-1:0] b, input int l, input logic [BW-1:0] be);
        logic          accept;
        logic [AW-1:0] a;
        @(posedge CLK); #1;
        start = 1'b1; base_addr = b; len = (AW+1)'(l); last_be = be;
        accept = !busy;
        if (accept) begin
            for (int k = 0; k < l; k++) begin
                a = AW'(int'(b) + k);
                exp_q.push_back('{data: mem[a], be: (k == l - 1) ? be : '1, last: (k == l - 1)});
                addr_q.push_back(a);
            end
        end
        @(posedge CLK);
        if (accept && l == 0) zero_req++;
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || m_valid || done || exp_q.size() != 0) && n < bound) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= bound) begin
            checks++; failures++;
            $display("FAIL timeout actual=busy%0d_pending%0d required=idle", busy, exp_q.size());
        end
    endtask

    task automatic run_cmd(input logic [AW-1:0] b, input int l, input logic [BW-1:0] be,
                           input int mode);
        ready_mode = mode;
        issue(b, l, be);
        wait_idle(l * 6 + 50);
        $display("cmd base=0x%03h len=%0d last_be=%b ready_mode=%0d complete", b, l, be, mode);
    endtask

    initial begin
        int first_valid;
        int done_at;
        int hs0;
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_outputs", 64'({busy, done, mem_ce, m_valid, m_last}), 64'd0);
        chk("rst_buses", 64'({mem_a, m_be, mem_we}), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        rst = 1'b0;

        // Latency and throughput for a short burst under continuous ready.
        ready_mode = 0;
        repeat (2) @(posedge CLK);
        issue(12'h010, 4, 4'b0011);
        chk("first_read_ce", 64'(mem_ce), 64'd1);
        first_valid = -1; done_at = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            if (m_valid && first_valid < 0) first_valid = k;
            if (done && done_at < 0) done_at = k;
        end
        chk("first_valid_cycle", 64'(first_valid), 64'd2);
        chk("done_cycle", 64'(done_at), 64'd6);
        wait_idle(50);
        $display("cmd base=0x010 len=4 last_be=0011 ready_mode=0 complete");

        run_cmd(12'hFFE, 4, 4'b1000, 0);
        run_cmd(12'h123, 8, 4'b0110, 1);

        // Zero-length command: only a done pulse.
        issue(12'h055, 0, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            chk("len0_quiet", 64'({busy, mem_ce, m_valid}), 64'd0);
            @(posedge CLK); #1;
        end
        wait_idle(20);
        $display("cmd base=0x055 len=0 complete");

        // A start while busy must be ignored.
        ready_mode = 2;
        issue(12'h100, 6, 4'b0111);
        @(posedge CLK); #1;
        chk("busy_during_cmd", 64'(busy), 64'd1);
        issue(12'h300, 3, 4'b1111);
        wait_idle(100);
        $display("cmd base=0x100 len=6 with ignored second start complete");

        // Reset in the middle of a transfer.
        ready_mode = 1;
        hs0 = hs_count;
        issue(12'h040, 8, 4'b0101);
        n = 0;
        while (hs_count < hs0 + 3 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("mid_rst_reached", 64'(hs_count >= hs0 + 3), 64'd1);
        rst = 1'b1;
        @(posedge CLK); #1;
        chk("mid_rst_outputs", 64'({busy, done, mem_ce, m_valid, m_last}), 64'd0);
        chk("mid_rst_buses", 64'({mem_a, m_be, m_data}), 64'd0);
        exp_q.delete();
        addr_q.delete();
        rst = 1'b0;
        $display("cmd base=0x040 len=8 aborted by reset");
        run_cmd(12'h200, 5, 4'b0011, 2);

        // Random contents and commands.
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int t = 0; t < 14; t++) begin
            int l;
            case ($urandom_range(0, 3))
                0:       l = 0;
                1:       l = 1;
                default: l = $urandom_range(2, 40);
            endcase
            run_cmd(AW'($urandom), l, BW'($urandom), $urandom_range(0, 2));
        end
        run_cmd(AW'($urandom), DEPTH, BW'($urandom), 0);

        repeat (3) @(posedge CLK);
        #1;
        chk("queue_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
